// File: rtl/mem_access.sv
// Memory-access stage: passes ALU results through, runs a req/ack bus
// transaction for loads/stores (stalling the pipe), and extends load data.
module mem_access #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        whilo_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        err_o
);

  localparam logic [3:0] OP_LB  = 4'b1000;
  localparam logic [3:0] OP_LBU = 4'b1001;
  localparam logic [3:0] OP_LH  = 4'b1010;
  localparam logic [3:0] OP_LHU = 4'b1011;
  localparam logic [3:0] OP_LW  = 4'b1100;
  localparam logic [3:0] OP_SB  = 4'b1101;
  localparam logic [3:0] OP_SH  = 4'b1110;
  localparam logic [3:0] OP_SW  = 4'b1111;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state, next;
  logic [TO_W-1:0] cnt;
  logic [31:0]     rdata_q;
  logic [3:0]      op_q;
  logic [1:0]      addr_q;
  logic            to_q;

  logic        is_load, is_store, is_half, is_word, misal, mem_op;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c, ext_data;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Request decode
  always_comb begin
    is_load  = mem_op_i inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    is_store = mem_op_i inside {OP_SB, OP_SH, OP_SW};
    is_half  = mem_op_i inside {OP_LH, OP_LHU, OP_SH};
    is_word  = mem_op_i inside {OP_LW, OP_SW};
    mem_op   = is_load | is_store;
    misal    = (is_half & mem_addr_i[0]) | (is_word & (|mem_addr_i[1:0]));
  end

  // Big-endian lane select and replicated store data
  always_comb begin
    sel_c   = 4'b0000;
    wdata_c = 32'h0;
    case (mem_op_i)
      OP_LB, OP_LBU, OP_SB: sel_c = 4'b1000 >> mem_addr_i[1:0];
      OP_LH, OP_LHU, OP_SH: sel_c = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      OP_LW, OP_SW:         sel_c = 4'b1111;
      default:              sel_c = 4'b0000;
    endcase
    case (mem_op_i)
      OP_SB:   wdata_c = {4{mem_sdata_i[7:0]}};
      OP_SH:   wdata_c = {2{mem_sdata_i[15:0]}};
      OP_SW:   wdata_c = mem_sdata_i;
      default: wdata_c = 32'h0;
    endcase
  end

  // Load extraction uses the op and offset captured at request time
  always_comb begin
    case (addr_q)
      2'd0:    byte_v = rdata_q[31:24];
      2'd1:    byte_v = rdata_q[23:16];
      2'd2:    byte_v = rdata_q[15:8];
      default: byte_v = rdata_q[7:0];
    endcase
    half_v = addr_q[1] ? rdata_q[15:0] : rdata_q[31:16];
    case (op_q)
      OP_LB:   ext_data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  ext_data = {24'h0, byte_v};
      OP_LH:   ext_data = {{16{half_v[15]}}, half_v};
      OP_LHU:  ext_data = {16'h0, half_v};
      default: ext_data = rdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next       = state;
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    hi_o       = hi_i;
    lo_o       = lo_i;
    whilo_o    = whilo_i;
    stallreq_o = 1'b0;
    err_o      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          wreg_o = 1'b0;
          if (misal) begin
            err_o = 1'b1;
          end else begin
            stallreq_o = 1'b1;
            next       = ACCESS;
          end
        end
      end
      ACCESS: begin
        wreg_o     = 1'b0;
        stallreq_o = 1'b1;
        if (bus_ack_i || cnt == TO_LAST) next = DONE;
      end
      DONE: begin
        next = IDLE;
        if (to_q) begin
          wreg_o = 1'b0;
          err_o  = 1'b1;
        end else if (op_q inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW}) begin
          wdata_o = ext_data;
        end
      end
      default: next = IDLE;
    endcase
    if (rst) begin
      next       = IDLE;
      wd_o       = 5'h0;
      wreg_o     = 1'b0;
      wdata_o    = 32'h0;
      hi_o       = 32'h0;
      lo_o       = 32'h0;
      whilo_o    = 1'b0;
      stallreq_o = 1'b0;
      err_o      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'h0;
      bus_sel_o   <= 4'h0;
      bus_wdata_o <= 32'h0;
      cnt         <= '0;
      rdata_q     <= 32'h0;
      op_q        <= 4'h0;
      addr_q      <= 2'b00;
      to_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (next == ACCESS) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_store;
            bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            bus_sel_o   <= sel_c;
            bus_wdata_o <= wdata_c;
            cnt         <= '0;
            op_q        <= mem_op_i;
            addr_q      <= mem_addr_i[1:0];
            to_q        <= 1'b0;
          end
        end
        ACCESS: begin
          if (bus_ack_i) begin
            rdata_q   <= bus_rdata_i;
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
            bus_sel_o <= 4'h0;
          end else begin
            cnt <= cnt + 1'b1;
            // Ack takes priority, so the abandon path only fires without one
            if (cnt == TO_LAST) begin
              bus_req_o   <= 1'b0;
              bus_we_o    <= 1'b0;
              bus_addr_o  <= 32'h0;
              bus_sel_o   <= 4'h0;
              bus_wdata_o <= 32'h0;
              to_q        <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
